// File: rtl/act_cell_rr_scheduler.sv
// Round-robin sharing of one 4:1 mux-plus-flop cell among four requesters; grant one edge after request,
// data+ack one edge later, back to IDLE on the third edge. No grants while hold=1 in IDLE; withdrawn requests abort.
module act_cell_rr_scheduler #(
    parameter int N = 8
) (
    input  logic         CLK,
    input  logic         CLR,
    input  logic [3:0]   req,
    input  logic         hold,
    input  logic [N-1:0] din0,
    input  logic [N-1:0] din1,
    input  logic [N-1:0] din2,
    input  logic [N-1:0] din3,
    output logic [3:0]   gnt,
    output logic         sel_a1,
    output logic         sel_b1,
    output logic         sel_a0,
    output logic         sel_b0,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic [1:0]   dout_id,
    output logic [3:0]   ack,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [1:0]   idx_q, idx_d;
    logic [3:0]   gnt_q, gnt_d;
    logic [3:0]   sel_q, sel_d;       // {a1, b1, a0, b0}
    logic [N-1:0] dout_q, dout_d;
    logic         vld_q, vld_d;
    logic [1:0]   id_q, id_d;
    logic [3:0]   ack_q, ack_d;

    logic         win_vld;
    logic [1:0]   win_idx;
    logic [1:0]   cand;
    logic         cell_s1, cell_s0;
    logic [N-1:0] cell_y;

    // Scan from the farthest offset down so the nearest requester to ptr wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr_q;
        cand    = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr_q + 2'(i);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // The shared cell: S1 = A1|B1, S0 = A0&B0 selecting D00..D11.
    assign cell_s1 = sel_q[3] | sel_q[2];
    assign cell_s0 = sel_q[1] & sel_q[0];

    always_comb begin
        cell_y = din0;
        case ({cell_s1, cell_s0})
            2'b00:   cell_y = din0;
            2'b01:   cell_y = din1;
            2'b10:   cell_y = din2;
            default: cell_y = din3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        dout_d  = dout_q;
        id_d    = id_q;
        vld_d   = 1'b0;
        ack_d   = 4'b0000;
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                sel_d = 4'b0000;
                if (!hold && win_vld) begin
                    idx_d   = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    sel_d   = {win_idx[1], 1'b0, win_idx[0], win_idx[0]};
                    state_d = SEL;
                end
            end
            SEL: begin
                if (req[idx_q]) begin
                    dout_d  = cell_y;
                    id_d    = idx_q;
                    vld_d   = 1'b1;
                    ack_d   = gnt_q;
                    state_d = DONE;
                end else begin
                    gnt_d   = 4'b0000;
                    sel_d   = 4'b0000;
                    state_d = IDLE;
                end
            end
            DONE: begin
                gnt_d   = 4'b0000;
                sel_d   = 4'b0000;
                ptr_d   = idx_q + 2'd1;
                state_d = IDLE;
            end
            default: begin
                gnt_d   = 4'b0000;
                sel_d   = 4'b0000;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            gnt_q   <= 4'b0000;
            sel_q   <= 4'b0000;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            id_q    <= 2'd0;
            ack_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            ack_q   <= ack_d;
        end
    end

    assign gnt        = gnt_q;
    assign sel_a1     = sel_q[3];
    assign sel_b1     = sel_q[2];
    assign sel_a0     = sel_q[1];
    assign sel_b0     = sel_q[0];
    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign dout_id    = id_q;
    assign ack        = ack_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_act_cell_rr_scheduler.sv
// Directed bench for act_cell_rr_scheduler: reset, single request, abort, withdrawal, hold, select mapping, fairness.
module tb_act_cell_rr_scheduler;

    logic       CLK;
    logic       CLR;
    logic [3:0] req;
    logic       hold;
    logic [7:0] din0, din1, din2, din3;
    logic [3:0] gnt;
    logic       sel_a1, sel_b1, sel_a0, sel_b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] dout_id;
    logic [3:0] ack;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    act_cell_rr_scheduler #(.N(8)) dut (
        .CLK(CLK), .CLR(CLR), .req(req), .hold(hold),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .gnt(gnt), .sel_a1(sel_a1), .sel_b1(sel_b1), .sel_a0(sel_a0), .sel_b0(sel_b0),
        .dout(dout), .dout_valid(dout_valid), .dout_id(dout_id), .ack(ack), .busy(busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        din0 = a; din1 = b; din2 = c; din3 = d;
    endtask

    // Reference behaviour of the shared cell's mux from its four select lines.
    function automatic logic [7:0] cell_ref(input logic a1, input logic b1, input logic a0, input logic b0);
        case ({a1 | b1, a0 & b0})
            2'b00:   return din0;
            2'b01:   return din1;
            2'b10:   return din2;
            default: return din3;
        endcase
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt"},  32'(gnt), 32'h0);
        chk({tag, "_sel"},  32'({sel_a1, sel_b1, sel_a0, sel_b0}), 32'h0);
        chk({tag, "_vld"},  32'(dout_valid), 32'h0);
        chk({tag, "_ack"},  32'(ack), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    initial begin
        logic [7:0] dtab [4];
        logic [7:0] ref_y;
        logic [3:0] pend_drop, pend_raise, req_n;
        int         got, last_cyc;

        CLR = 1'b1; req = 4'b0000; hold = 1'b0;
        set_din(8'h00, 8'h00, 8'h00, 8'h00);
        step(); step();

        // Reset state
        chk_idle_outputs("rst");
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_id",   32'(dout_id), 32'h0);
        CLR = 1'b0;
        step();

        // Single request from requester 1
        set_din(8'h00, 8'hA5, 8'h5C, 8'h00);
        req = 4'b0010;
        step();
        chk("single_gnt",  32'(gnt), 32'h2);
        chk("single_sel",  32'({sel_a1, sel_b1, sel_a0, sel_b0}), 32'b0011);
        chk("single_busy", 32'(busy), 32'h1);
        chk("single_vld0", 32'(dout_valid), 32'h0);
        step();
        chk("single_dout", 32'(dout), 32'hA5);
        chk("single_id",   32'(dout_id), 32'h1);
        chk("single_vld",  32'(dout_valid), 32'h1);
        chk("single_ack",  32'(ack), 32'h2);
        req = 4'b0000;
        step();
        chk_idle_outputs("single_end");
        chk("single_hold_dout", 32'(dout), 32'hA5);
        chk("single_hold_id",   32'(dout_id), 32'h1);

        // Reset in the middle of a SEL cycle
        req = 4'b0100;
        step();
        chk("abort_gnt_pre", 32'(gnt), 32'h4);
        #2 CLR = 1'b1;
        #1;
        chk_idle_outputs("abort_async");
        chk("abort_dout", 32'(dout), 32'h0);
        step();
        CLR = 1'b0;
        chk("abort_noack", 32'(ack), 32'h0);
        step();
        chk("abort_regnt",  32'(gnt), 32'h4);
        chk("abort_sel",    32'({sel_a1, sel_b1, sel_a0, sel_b0}), 32'b1000);
        step();
        chk("abort_ack",  32'(ack), 32'h4);
        chk("abort_dout2", 32'(dout), 32'h5C);
        req = 4'b0000;
        step();

        // Withdrawal leaves the pointer in place
        CLR = 1'b1; step(); CLR = 1'b0;
        set_din(8'h10, 8'h21, 8'h32, 8'h43);
        req = 4'b1000;
        step();
        chk("wd_gnt", 32'(gnt), 32'h8);
        chk("wd_sel", 32'({sel_a1, sel_b1, sel_a0, sel_b0}), 32'b1011);
        req = 4'b0000;
        step();
        chk_idle_outputs("wd_abort");
        req = 4'b1001;
        step();
        chk("wd_next_gnt", 32'(gnt), 32'h1);
        step();
        chk("wd_next_ack",  32'(ack), 32'h1);
        chk("wd_next_dout", 32'(dout), 32'h10);
        req = 4'b0000;
        step();
        req = 4'b0010;
        step();
        chk("wd2_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        step();
        chk("wd2_vld", 32'(dout_valid), 32'h0);
        req = 4'b0011;
        step();
        chk("wd2_ptr_gnt", 32'(gnt), 32'h2);
        step();
        chk("wd2_dout", 32'(dout), 32'h21);
        req = 4'b0000;
        step();

        // hold blocks new grants in IDLE only
        hold = 1'b1;
        req  = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_gnt",  32'(gnt), 32'h0);
            chk("hold_busy", 32'(busy), 32'h0);
        end
        hold = 1'b0;
        step();
        chk("hold_rel_gnt", 32'(gnt), 32'h1);
        hold = 1'b1;
        step();
        chk("hold_sel_ack",  32'(ack), 32'h1);
        chk("hold_sel_dout", 32'(dout), 32'h10);
        req  = 4'b0000;
        hold = 1'b0;
        step();

        // Select-line mapping against the cell reference
        dtab[0] = 8'h5A; dtab[1] = 8'hC3; dtab[2] = 8'h0F; dtab[3] = 8'hE7;
        set_din(dtab[0], dtab[1], dtab[2], dtab[3]);
        for (int k = 0; k < 4; k++) begin
            req = 4'b0001 << k;
            step();
            chk("map_gnt", 32'(gnt), 32'(4'b0001 << k));
            chk("map_s1",  32'(sel_a1 | sel_b1), 32'(k / 2));
            chk("map_s0",  32'(sel_a0 & sel_b0), 32'(k % 2));
            ref_y = cell_ref(sel_a1, sel_b1, sel_a0, sel_b0);
            step();
            chk("map_dout_ref", 32'(dout), 32'(ref_y));
            chk("map_dout_tab", 32'(dout), 32'(dtab[k]));
            chk("map_id",       32'(dout_id), 32'(k));
            req = 4'b0000;
            step();
        end

        // Round-robin fairness with all four requesting
        CLR = 1'b1; step(); CLR = 1'b0;
        dtab[0] = 8'h10; dtab[1] = 8'h21; dtab[2] = 8'h32; dtab[3] = 8'h43;
        set_din(dtab[0], dtab[1], dtab[2], dtab[3]);
        req        = 4'b1111;
        pend_drop  = 4'b0000;
        pend_raise = 4'b0000;
        got        = 0;
        last_cyc   = -1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            step();
            chk("rr_onehot", 32'($countones(gnt) <= 1), 32'h1);
            if (dout_valid) begin
                chk("rr_id",   32'(dout_id), 32'(got % 4));
                chk("rr_dout", 32'(dout), 32'(dtab[got % 4]));
                if (last_cyc >= 0)
                    chk("rr_gap", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                got++;
            end
            req_n = req | pend_raise;
            req_n = req_n & ~pend_drop;
            pend_raise = pend_drop;
            pend_drop  = ack;
            req = req_n;
        end
        chk("rr_count", 32'(got), 32'd5);
        req = 4'b0000;
        step(); step(); step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
